areg_arb: RTL and testbench
===========================

Name: areg_arb

Overview:
- Round-robin arbiter and sequencer for the shared `areg` register file, which has one read port and one write port.
- Lets NREQ requesters issue read, overwrite or accumulate ops over valid/ready, at a throughput of one op per cycle.
- Drives the `areg` control ports directly and returns read data one cycle after the handshake.
- Provides a bounded lock for atomic read-modify-write sequences.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LOCK_MAX, 16, maximum number of cycles a lock may be held before it is forcibly released (≥2).

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- req_v  in  NREQ  request valid, one bit per requester.
- req_rdy  out  NREQ  request ready (one-hot grant).
- req_wr  in  NREQ  op select: 1 = write, 0 = read.
- req_lock  in  NREQ  hold the lock after this op.
- req_addr  in  NREQ*4  register index per requester, packed.
- req_y  in  NREQ  write mode: 1 = overwrite, 0 = accumulate.
- req_wval  in  NREQ*`BITNESS  write data / addend, packed.
- req_mask  in  NREQ*`BITNESS  write mask, packed.
- rsp_v  out  NREQ  read response valid, one-hot.
- rsp_data  out  `BITNESS  read response data.
- ra  out  4  to `areg`.
- rval  in  `BITNESS  from `areg`.
- w, y  out  1 each  to `areg`.
- wa  out  4  to `areg`.
- wval, mask  out  `BITNESS each  to `areg`.
- locked  out  1  lock currently held.
- lock_owner  out  $clog2(NREQ)  index of the lock holder; 0 when not locked.
- lock_err  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Handshake
  - A transfer on requester i happens when req_v[i] && req_rdy[i].
  - Requesters hold valid and payload stable until ready.
  - req_rdy is combinational and may depend on req_v.
  - At most one bit of req_rdy is set per cycle.
  - req_rdy[i] is never set unless req_v[i] is set.
- Arbitration
  - Round-robin pointer ptr holds the last granted index.
  - Search starts at ptr+1 and wraps modulo NREQ.
  - ptr updates to the granted index on every transfer.
  - Reset value of ptr is NREQ-1, so requester 0 wins first.
- `areg` drive (combinational from the granted requester)
  - ra = wa = granted addr.
  - w = granted && req_wr.
  - y, wval and mask come from the granted requester's payload.
  - With no grant: w=0 and ra/wa/y/wval/mask=0.
- Read path
  - rval is sampled at the transfer edge into rsp_data.
  - rsp_v[i] pulses for exactly one cycle, one cycle after the read transfer.
  - rsp_data holds its value until the next read.
  - A read issued the cycle after a write sees the written value.
  - This includes the mirror: a write to k<8 is visible at k+8.
  - The arbiter does no mirror or hazard handling itself.
- Write path: no response; the write commits at the transfer edge.
- Lock FSM, states IDLE and LOCKED
  - IDLE → LOCKED: on a transfer with req_lock=1. Set owner = granted index, cnt = 0.
  - In LOCKED: only the owner is eligible; all other req_rdy = 0.
  - cnt increments every LOCKED cycle and is not reset by owner transfers.
  - LOCKED → IDLE (normal release): on an owner transfer with req_lock=0. That op executes.
  - LOCKED → IDLE (forced release): at the edge where cnt == LOCK_MAX-1 and no normal release occurs. Any owner transfer in that cycle still executes. Set ptr = owner; lock_err is registered high for the following cycle.
  - If a normal release and the timeout coincide: normal release, no lock_err.
- Status outputs: locked = (state == LOCKED); lock_owner = owner when locked, else 0.
- Reset values
  - Registered: state=IDLE, ptr=NREQ-1, cnt=0, owner=0, rsp_v=0, rsp_data=0, lock_err=0.
  - Combinational outputs follow from the reset state.
- Reset mid-operation: pending responses and locks are dropped with no pulse afterward.

Decomposition:
- Package areg_pkg:
  - NREGS=16 and MIRROR_BASE=8.
  - Typedef areg_addr_t for logic[3:0].
  - Enum lock_state_t {IDLE, LOCKED}.
- Word width comes from the existing `WORD/`BITNESS in commons.sv.
- One sub-module, rr_pick: a parameterised round-robin one-hot picker.
  - Inputs: req vector, pointer, eligibility mask.
  - Output: one-hot grant.

Test Plan (NREQ=2, LOCK_MAX=4, `BITNESS=32):
- Overwrite + mirror: r0 writes addr 3, wval 0x10, y=1, mask 0xFFFFFFFF; next cycle r1 reads addr 11 → rsp_v[1] one cycle later, rsp_data=0x10.
- Accumulate: r0 writes addr 2, y=0, wval 5, twice, then reads addr 2 → rsp_data=0xA.
- Round-robin: both requesters hold valid reads from the first cycle after reset → grants 0,1,0,1; rsp_v alternates one cycle behind.
- Lock: r0 reads with lock=1 while r1 is continuously valid → req_rdy[1]=0 and locked=1 until r0's write with lock=0; r1 is granted the next cycle.
- Timeout: r0 reads with lock=1 and then goes idle while r1 is valid → lock_err high for exactly 1 cycle 4 cycles after the lock transfer, with r1 granted in that same cycle.
- Reset with a response pending: r0 read transfers, and rst is asserted before the next edge → rsp_v stays 0, and after release ptr=1 (r0 wins first).

Source files
------------

// File: rtl/areg_pkg.sv
// areg_pkg: shared types and constants for the areg register file and its
// arbiter. NREGS registers, indices below MIRROR_BASE are mirrored upward.
package areg_pkg;
  localparam int NREGS       = 16;
  localparam int MIRROR_BASE = 8;

  typedef logic [3:0] areg_addr_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;
endpackage

// File: rtl/areg_arb_rr_pick.sv
// rr_pick: round-robin one-hot picker.
//   req_i  - request vector
//   ptr_i  - last granted index; search starts at ptr_i+1 and wraps
//   elig_i - eligibility mask, ANDed with req_i
//   gnt_o  - one-hot grant (all zero when nothing eligible is requesting)
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic [N-1:0]  elig_i,
  output logic [N-1:0]  gnt_o
);
  logic found;
  int   idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!found && req_i[idx] && elig_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/commons.sv
// Shared word-width definitions for the areg subsystem.
`ifndef COMMONS_SV
`define COMMONS_SV
`ifndef WORD
`define WORD 32
`endif
`ifndef BITNESS
`define BITNESS `WORD
`endif
`endif

// File: rtl/areg_arb.sv
// areg_arb: round-robin arbiter/sequencer for the single-read, single-write
// areg register file, with a bounded lock for read-modify-write sequences.
// Ports:
//   clk, rst                          - clock, async active-high reset
//   req_v/req_rdy                     - per-requester valid / one-hot ready
//   req_wr, req_lock, req_addr, req_y,
//   req_wval, req_mask                - packed per-requester op payload
//   rsp_v, rsp_data                   - read response, one cycle after transfer
//   ra, rval, w, y, wa, wval, mask    - areg control ports
//   locked, lock_owner, lock_err      - lock status, forced-release pulse
`ifndef BITNESS
`define BITNESS 32
`endif
module areg_arb
  import areg_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_v,
  output logic [NREQ-1:0]           req_rdy,
  input  logic [NREQ-1:0]           req_wr,
  input  logic [NREQ-1:0]           req_lock,
  input  logic [NREQ*4-1:0]         req_addr,
  input  logic [NREQ-1:0]           req_y,
  input  logic [NREQ*`BITNESS-1:0]  req_wval,
  input  logic [NREQ*`BITNESS-1:0]  req_mask,
  output logic [NREQ-1:0]           rsp_v,
  output logic [`BITNESS-1:0]       rsp_data,
  output logic [3:0]                ra,
  input  logic [`BITNESS-1:0]       rval,
  output logic                      w,
  output logic                      y,
  output logic [3:0]                wa,
  output logic [`BITNESS-1:0]       wval,
  output logic [`BITNESS-1:0]       mask,
  output logic                      locked,
  output logic [$clog2(NREQ)-1:0]   lock_owner,
  output logic                      lock_err
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_MAX);

  lock_state_t         state_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       owner_q;
  logic [CW-1:0]       cnt_q;
  logic [NREQ-1:0]     rsp_v_q;
  logic [`BITNESS-1:0] rsp_data_q;
  logic                lock_err_q;

  logic [NREQ-1:0]     elig;
  logic [NREQ-1:0]     gnt;
  logic [PW-1:0]       gidx;
  logic                xfer;
  areg_addr_t          addr_g;

  // While locked only the owner may be granted.
  always_comb begin
    elig = '1;
    if (state_q == LOCKED) elig = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
  end

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req_i  (req_v),
    .ptr_i  (ptr_q),
    .elig_i (elig),
    .gnt_o  (gnt)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gidx = PW'(i);
    end
  end

  assign xfer    = |gnt;
  assign req_rdy = gnt;

  always_comb begin
    addr_g = '0;
    w      = 1'b0;
    y      = 1'b0;
    wval   = '0;
    mask   = '0;
    if (xfer) begin
      addr_g = req_addr[int'(gidx)*4 +: 4];
      w      = req_wr[gidx];
      y      = req_y[gidx];
      wval   = req_wval[int'(gidx)*`BITNESS +: `BITNESS];
      mask   = req_mask[int'(gidx)*`BITNESS +: `BITNESS];
    end
  end

  assign ra = addr_g;
  assign wa = addr_g;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= PW'(NREQ-1);
      owner_q    <= '0;
      cnt_q      <= '0;
      rsp_v_q    <= '0;
      rsp_data_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      lock_err_q <= 1'b0;
      rsp_v_q    <= '0;
      if (xfer) ptr_q <= gidx;
      if (xfer && !req_wr[gidx]) begin
        rsp_v_q    <= gnt;
        rsp_data_q <= rval;
      end
      case (state_q)
        IDLE: begin
          if (xfer && req_lock[gidx]) begin
            state_q <= LOCKED;
            owner_q <= gidx;
            cnt_q   <= '0;
          end
        end
        LOCKED: begin
          cnt_q <= cnt_q + 1'b1;
          // A grant here is necessarily the owner; normal release wins
          // over a coincident timeout.
          if (xfer && !req_lock[gidx]) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(LOCK_MAX-1)) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= owner_q;
            lock_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_v      = rsp_v_q;
  assign rsp_data   = rsp_data_q;
  assign lock_err   = lock_err_q;
  assign locked     = (state_q == LOCKED);
  assign lock_owner = (state_q == LOCKED) ? owner_q : '0;
endmodule

// File: tb/tb_areg_arb.sv
`ifndef BITNESS
`define BITNESS 32
`endif
module tb_areg_arb;
  logic        clk;
  logic        rst;
  logic [1:0]  req_v, req_rdy, req_wr, req_lock, req_y, rsp_v;
  logic [7:0]  req_addr;
  logic [63:0] req_wval, req_mask;
  logic [31:0] rsp_data, rval, wval, mask;
  logic [3:0]  ra, wa;
  logic        w, y, locked, lock_err;
  logic [0:0]  lock_owner;

  int n_tests = 0;
  int n_fail  = 0;

  areg_arb #(.NREQ(2), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst), .req_v(req_v), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_lock(req_lock), .req_addr(req_addr), .req_y(req_y),
    .req_wval(req_wval), .req_mask(req_mask), .rsp_v(rsp_v),
    .rsp_data(rsp_data), .ra(ra), .rval(rval), .w(w), .y(y), .wa(wa),
    .wval(wval), .mask(mask), .locked(locked), .lock_owner(lock_owner),
    .lock_err(lock_err)
  );

  // Behavioural areg: 16 words, writes to k<8 also land at k+8.
  logic [31:0] mem [16] = '{default: 32'h0};
  logic [31:0] nv;
  assign rval = mem[ra];
  assign nv   = y ? ((mem[wa] & ~mask) | (wval & mask)) : (mem[wa] + (wval & mask));
  always @(posedge clk) begin
    if (w) begin
      mem[wa] <= nv;
      if (wa < 4'd8) mem[{1'b1, wa[2:0]}] <= nv;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic wr, input logic lk,
                         input logic [3:0] a, input logic yy,
                         input logic [31:0] d, input logic [31:0] m);
    req_v[i]             = v;
    req_wr[i]            = wr;
    req_lock[i]          = lk;
    req_addr[i*4 +: 4]   = a;
    req_y[i]             = yy;
    req_wval[i*32 +: 32] = d;
    req_mask[i*32 +: 32] = m;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (rsp_v !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_v got %b exp 00", rsp_v); end
    n_tests++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got %b exp 0", locked); end
    n_tests++; if (lock_owner !== 1'b0) begin n_fail++; $display("FAIL rst_owner got %b exp 0", lock_owner); end
    n_tests++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL rst_lock_err got %b exp 0", lock_err); end
    n_tests++; if (req_rdy !== 2'b00) begin n_fail++; $display("FAIL rst_rdy got %b exp 00", req_rdy); end
    n_tests++; if (w !== 1'b0 || ra !== 4'h0) begin n_fail++; $display("FAIL rst_drive got w=%b ra=%h exp 0/0", w, ra); end
    rst = 1'b0;
  endtask

  task automatic test_overwrite_mirror();
    step(); set_req(0, 1, 1, 0, 4'd3, 1, 32'h10, 32'hFFFF_FFFF);
    @(negedge clk);
    n_tests++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL ow_rdy got %b exp 01", req_rdy); end
    n_tests++; if (w !== 1'b1 || wa !== 4'd3 || wval !== 32'h10 || y !== 1'b1)
      begin n_fail++; $display("FAIL ow_drive got w=%b wa=%h wval=%h y=%b exp 1/3/10/1", w, wa, wval, y); end
    step(); set_req(0, 0, 0, 0, 0, 0, 0, 0); set_req(1, 1, 0, 0, 4'd11, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (req_rdy !== 2'b10) begin n_fail++; $display("FAIL mir_rdy got %b exp 10", req_rdy); end
    n_tests++; if (ra !== 4'd11 || w !== 1'b0) begin n_fail++; $display("FAIL mir_drive got ra=%h w=%b exp b/0", ra, w); end
    n_tests++; if (rsp_v !== 2'b00) begin n_fail++; $display("FAIL ow_no_rsp got %b exp 00", rsp_v); end
    step(); set_req(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (rsp_v !== 2'b10) begin n_fail++; $display("FAIL mir_rsp_v got %b exp 10", rsp_v); end
    n_tests++; if (rsp_data !== 32'h10) begin n_fail++; $display("FAIL mir_rsp_data got %h exp 10", rsp_data); end
    step();
    @(negedge clk);
    n_tests++; if (rsp_v !== 2'b00) begin n_fail++; $display("FAIL mir_pulse got %b exp 00", rsp_v); end
    n_tests++; if (rsp_data !== 32'h10) begin n_fail++; $display("FAIL mir_hold got %h exp 10", rsp_data); end
  endtask

  task automatic test_accumulate();
    step(); set_req(0, 1, 1, 0, 4'd2, 0, 32'd5, 32'hFFFF_FFFF);
    @(negedge clk);
    n_tests++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL acc_rdy1 got %b exp 01", req_rdy); end
    step();
    @(negedge clk);
    n_tests++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL acc_rdy2 got %b exp 01", req_rdy); end
    step(); set_req(0, 1, 0, 0, 4'd2, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (ra !== 4'd2 || w !== 1'b0) begin n_fail++; $display("FAIL acc_read got ra=%h w=%b exp 2/0", ra, w); end
    step(); set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (rsp_v !== 2'b01) begin n_fail++; $display("FAIL acc_rsp_v got %b exp 01", rsp_v); end
    n_tests++; if (rsp_data !== 32'hA) begin n_fail++; $display("FAIL acc_rsp_data got %h exp a", rsp_data); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g [4];
    logic [31:0] exp_d [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_d = '{32'hAAAA, 32'h5555, 32'hAAAA, 32'h5555};
    step(); set_req(1, 1, 1, 0, 4'd6, 1, 32'h5555, 32'hFFFF_FFFF);
    step(); set_req(1, 0, 0, 0, 0, 0, 0, 0); set_req(0, 1, 1, 0, 4'd1, 1, 32'hAAAA, 32'hFFFF_FFFF);
    step(); set_req(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    set_req(0, 1, 0, 0, 4'd1, 0, 0, 0); set_req(1, 1, 0, 0, 4'd6, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++; if (req_rdy !== exp_g[k]) begin n_fail++; $display("FAIL rr_gnt%0d got %b exp %b", k, req_rdy, exp_g[k]); end
      if (k > 0) begin
        n_tests++; if (rsp_v !== exp_g[k-1] || rsp_data !== exp_d[k-1])
          begin n_fail++; $display("FAIL rr_rsp%0d got %b/%h exp %b/%h", k, rsp_v, rsp_data, exp_g[k-1], exp_d[k-1]); end
      end
    end
    step(); set_req(0, 0, 0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (rsp_v !== 2'b10 || rsp_data !== 32'h5555)
      begin n_fail++; $display("FAIL rr_rsp_last got %b/%h exp 10/5555", rsp_v, rsp_data); end
  endtask

  task automatic test_lock();
    step(); set_req(0, 1, 0, 1, 4'd1, 0, 0, 0); set_req(1, 1, 0, 0, 4'd6, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL lk_rdy0 got %b exp 01", req_rdy); end
    step(); set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (locked !== 1'b1 || lock_owner !== 1'b0) begin n_fail++; $display("FAIL lk_state got %b/%b exp 1/0", locked, lock_owner); end
    n_tests++; if (req_rdy !== 2'b00) begin n_fail++; $display("FAIL lk_block got %b exp 00", req_rdy); end
    n_tests++; if (rsp_v !== 2'b01 || rsp_data !== 32'hAAAA) begin n_fail++; $display("FAIL lk_rsp got %b/%h exp 01/aaaa", rsp_v, rsp_data); end
    step(); set_req(0, 1, 1, 0, 4'd5, 1, 32'h77, 32'hFFFF_FFFF);
    @(negedge clk);
    n_tests++; if (req_rdy !== 2'b01 || locked !== 1'b1 || w !== 1'b1)
      begin n_fail++; $display("FAIL lk_wr got rdy=%b lk=%b w=%b exp 01/1/1", req_rdy, locked, w); end
    step(); set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (locked !== 1'b0 || req_rdy !== 2'b10) begin n_fail++; $display("FAIL lk_rel got lk=%b rdy=%b exp 0/10", locked, req_rdy); end
    n_tests++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL lk_no_err got %b exp 0", lock_err); end
    step(); set_req(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (rsp_v !== 2'b10 || rsp_data !== 32'h5555) begin n_fail++; $display("FAIL lk_r1_rsp got %b/%h exp 10/5555", rsp_v, rsp_data); end
  endtask

  task automatic test_timeout();
    step(); set_req(0, 1, 0, 1, 4'd5, 0, 0, 0); set_req(1, 1, 0, 0, 4'd6, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL to_rdy0 got %b exp 01", req_rdy); end
    step(); set_req(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_tests++; if (locked !== 1'b1 || req_rdy !== 2'b00 || lock_err !== 1'b0)
        begin n_fail++; $display("FAIL to_hold%0d got lk=%b rdy=%b err=%b exp 1/00/0", c, locked, req_rdy, lock_err); end
      if (c == 1) begin
        n_tests++; if (rsp_data !== 32'h77) begin n_fail++; $display("FAIL to_rsp got %h exp 77", rsp_data); end
      end
    end
    @(negedge clk);
    n_tests++; if (lock_err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b exp 1", lock_err); end
    n_tests++; if (locked !== 1'b0 || req_rdy !== 2'b10) begin n_fail++; $display("FAIL to_rel got lk=%b rdy=%b exp 0/10", locked, req_rdy); end
    step(); set_req(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got %b exp 0", lock_err); end
  endtask

  task automatic test_reset_pending();
    step(); set_req(0, 1, 0, 0, 4'd1, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL rp_rdy got %b exp 01", req_rdy); end
    step(); rst = 1'b1; set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (rsp_v !== 2'b00 || rsp_data !== 32'h0) begin n_fail++; $display("FAIL rp_drop got %b/%h exp 00/0", rsp_v, rsp_data); end
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    @(negedge clk);
    n_tests++; if (rsp_v !== 2'b00 || locked !== 1'b0) begin n_fail++; $display("FAIL rp_after got %b/%b exp 00/0", rsp_v, locked); end
    step(); set_req(0, 1, 0, 0, 4'd1, 0, 0, 0); set_req(1, 1, 0, 0, 4'd6, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL rp_ptr got %b exp 01", req_rdy); end
    step(); set_req(0, 0, 0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst      = 1'b1;
    req_v    = '0;
    req_wr   = '0;
    req_lock = '0;
    req_y    = '0;
    req_addr = '0;
    req_wval = '0;
    req_mask = '0;
    test_reset();
    test_overwrite_mirror();
    test_accumulate();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
